// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and multi-cycle
// mult/div freeze, with a saturating count of inserted stall cycles.
//
// state  | meaning
// RUN    | normal issue; resolves branch, mult/div entry and load-use hazards
// MDWAIT | pipeline frozen while a mult/div occupies EX; Cnt==0 is the done cycle
module hazard_ctrl #(
    parameter int MULDIV_CYCLES = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        IDEX_MemRead,
    input  logic [4:0]  IDEX_RegisterRt,
    input  logic [4:0]  IFID_RegisterRs,
    input  logic [4:0]  IFID_RegisterRt,
    input  logic        IFID_UsesRt,
    input  logic        IDEX_MulDiv,
    input  logic        Branch_Taken,
    output logic        PC_Write,
    output logic        IFID_Write,
    output logic        IDEX_Write,
    output logic        IDEX_Bubble,
    output logic        EXMEM_Bubble,
    output logic        IFID_Flush,
    output logic        IDEX_Flush,
    output logic        MulDiv_Done,
    output logic        Busy,
    output logic [15:0] Stall_Count
);

    typedef enum logic {RUN, MDWAIT} state_t;

    // The entry cycle in RUN and the done cycle each take one EX cycle.
    localparam logic [3:0] CNT_LOAD = 4'(MULDIV_CYCLES - 2);

    state_t     state, stateNext;
    logic [3:0] cnt;
    logic       loadUse;
    logic       stallCycle;
    logic       loadCnt;

    assign loadUse = IDEX_MemRead && (IDEX_RegisterRt != 5'd0) &&
                     ((IDEX_RegisterRt == IFID_RegisterRs) ||
                      (IFID_UsesRt && (IDEX_RegisterRt == IFID_RegisterRt)));

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= RUN;
            cnt         <= 4'd0;
            Stall_Count <= 16'd0;
        end else begin
            state <= stateNext;
            if (loadCnt)
                cnt <= CNT_LOAD;
            else if (state == MDWAIT && cnt != 4'd0)
                cnt <= cnt - 4'd1;
            if (stallCycle && Stall_Count != 16'hFFFF)
                Stall_Count <= Stall_Count + 16'd1;
        end
    end

    always_comb begin
        stateNext    = state;
        loadCnt      = 1'b0;
        stallCycle   = 1'b0;
        PC_Write     = 1'b1;
        IFID_Write   = 1'b1;
        IDEX_Write   = 1'b1;
        IDEX_Bubble  = 1'b0;
        EXMEM_Bubble = 1'b0;
        IFID_Flush   = 1'b0;
        IDEX_Flush   = 1'b0;
        MulDiv_Done  = 1'b0;
        Busy         = 1'b0;
        case (state)
            RUN: begin
                if (Branch_Taken) begin
                    IFID_Flush = 1'b1;
                    IDEX_Flush = 1'b1;
                end else if (IDEX_MulDiv) begin
                    PC_Write     = 1'b0;
                    IFID_Write   = 1'b0;
                    IDEX_Write   = 1'b0;
                    EXMEM_Bubble = 1'b1;
                    stallCycle   = 1'b1;
                    loadCnt      = 1'b1;
                    stateNext    = MDWAIT;
                end else if (loadUse) begin
                    PC_Write    = 1'b0;
                    IFID_Write  = 1'b0;
                    IDEX_Bubble = 1'b1;
                    stallCycle  = 1'b1;
                end
            end
            MDWAIT: begin
                // Inputs are deliberately ignored: the frozen pipeline holds them.
                Busy = 1'b1;
                if (cnt == 4'd0) begin
                    MulDiv_Done = 1'b1;
                    stateNext   = RUN;
                end else begin
                    PC_Write     = 1'b0;
                    IFID_Write   = 1'b0;
                    IDEX_Write   = 1'b0;
                    EXMEM_Bubble = 1'b1;
                    stallCycle   = 1'b1;
                end
            end
            default: stateNext = RUN;
        endcase
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the driver pushes model predictions per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_ctrl;

    localparam int MDC = 4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        IDEX_MemRead, IFID_UsesRt, IDEX_MulDiv, Branch_Taken;
    logic [4:0]  IDEX_RegisterRt, IFID_RegisterRs, IFID_RegisterRt;
    logic        PC_Write, IFID_Write, IDEX_Write, IDEX_Bubble, EXMEM_Bubble;
    logic        IFID_Flush, IDEX_Flush, MulDiv_Done, Busy;
    logic [15:0] Stall_Count;

    hazard_ctrl #(.MULDIV_CYCLES(MDC)) dut (
        .Clk(Clk), .Reset(Reset),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_RegisterRt(IDEX_RegisterRt),
        .IFID_RegisterRs(IFID_RegisterRs), .IFID_RegisterRt(IFID_RegisterRt),
        .IFID_UsesRt(IFID_UsesRt), .IDEX_MulDiv(IDEX_MulDiv), .Branch_Taken(Branch_Taken),
        .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IDEX_Write(IDEX_Write),
        .IDEX_Bubble(IDEX_Bubble), .EXMEM_Bubble(EXMEM_Bubble),
        .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush),
        .MulDiv_Done(MulDiv_Done), .Busy(Busy), .Stall_Count(Stall_Count)
    );

    always #5 Clk = ~Clk;

    // {PC,IFID,IDEX writes, IDEX_Bubble, EXMEM_Bubble, IFID_Flush, IDEX_Flush, Done, Busy, Stall_Count}
    logic [24:0] expQ[$];
    int checks = 0;
    int errors = 0;
    int cycleNo = 0;

    // Reference state: remaining EX cycles of an in-flight mult/div, and stall total.
    int mdLeft = 0;
    int stallTotal = 0;

    function automatic logic [24:0] predict(input logic rst, br, md, mr,
                                            input logic [4:0] exRt, idRs, idRt,
                                            input logic usesRt);
        logic pw, fw, dw, ib, eb, ff, df, dn, bz;
        logic lu;
        logic stall;
        logic [24:0] r;
        pw = 1; fw = 1; dw = 1; ib = 0; eb = 0; ff = 0; df = 0; dn = 0; bz = 0;
        stall = 0;
        if (!rst) begin
            mdLeft = 0;
            stallTotal = 0;
        end
        lu = mr && exRt != 0 && (exRt == idRs || (usesRt && exRt == idRt));
        if (mdLeft > 0) begin
            bz = 1;
            if (mdLeft == 1) dn = 1;
            else begin pw = 0; fw = 0; dw = 0; eb = 1; stall = 1; end
        end else if (br) begin
            ff = 1; df = 1;
        end else if (md) begin
            pw = 0; fw = 0; dw = 0; eb = 1; stall = 1;
        end else if (lu) begin
            pw = 0; fw = 0; ib = 1; stall = 1;
        end
        r = {pw, fw, dw, ib, eb, ff, df, dn, bz, 16'(stallTotal)};
        if (rst) begin
            if (mdLeft > 0) mdLeft = mdLeft - 1;
            else if (!br && md) mdLeft = MDC - 1;
            if (stall && stallTotal < 65535) stallTotal = stallTotal + 1;
        end
        return r;
    endfunction

    task automatic step(input logic rst, br, md, mr,
                        input logic [4:0] exRt, idRs, idRt, input logic usesRt);
        @(posedge Clk);
        #1;
        Reset = rst; Branch_Taken = br; IDEX_MulDiv = md; IDEX_MemRead = mr;
        IDEX_RegisterRt = exRt; IFID_RegisterRs = idRs; IFID_RegisterRt = idRt;
        IFID_UsesRt = usesRt;
        expQ.push_back(predict(rst, br, md, mr, exRt, idRs, idRt, usesRt));
    endtask

    always @(negedge Clk) begin
        logic [24:0] e, a;
        cycleNo++;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            a = {PC_Write, IFID_Write, IDEX_Write, IDEX_Bubble, EXMEM_Bubble,
                 IFID_Flush, IDEX_Flush, MulDiv_Done, Busy, Stall_Count};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL out_vec cyc=%0d got ctl=%b cnt=%0d expected ctl=%b cnt=%0d",
                         cycleNo, a[24:16], a[15:0], e[24:16], e[15:0]);
            end
        end
    end

    initial begin
        Reset = 0; Branch_Taken = 0; IDEX_MulDiv = 0; IDEX_MemRead = 0;
        IDEX_RegisterRt = 0; IFID_RegisterRs = 0; IFID_RegisterRt = 0; IFID_UsesRt = 0;
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // load-use on Rs, then normal
        step(1, 0, 0, 1, 8, 8, 3, 1);
        step(1, 0, 0, 0, 8, 8, 3, 1);
        // r0 load and Rt match without UsesRt: no stall
        step(1, 0, 0, 1, 0, 0, 0, 1);
        step(1, 0, 0, 1, 9, 2, 9, 0);
        step(1, 0, 0, 1, 9, 2, 9, 1);
        // branch wins over load-use
        step(1, 1, 0, 1, 5, 5, 5, 1);
        // full mult/div with junk inputs during the wait
        step(1, 0, 1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 4, 4, 4, 1);
        step(1, 0, 0, 1, 4, 4, 4, 1);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        // reset on second frozen cycle, applied between clock edges
        step(1, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0),
                 1'($urandom),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 1'($urandom));
        end
        // saturation: hold a load-use hazard past 65535 stalls
        step(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65540; i++)
            step(1, 0, 0, 1, 7, 7, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge Clk);
        #1;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
